// File: rtl/psum_xchg_fifo_if.sv
// Bus bundle between the local sum path (master side drives pushes/pops) and the exchange FIFO.
// Strobes only: in_wr/out_rd are single-cycle requests sampled at posedge, with no backpressure;
// the producer watches full/out_ready, and a refused request only raises the sticky error flags.
interface psum_xchg_fifo_if #(
  parameter int width = 160
);
  logic             in_wr;
  logic [width-1:0] in_data;
  logic             out_rd;
  logic [width-1:0] out_data;
  logic             out_ready;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output in_wr, in_data, out_rd,
    input  out_data, out_ready, full, empty, overflow, underflow
  );

  modport slave (
    input  in_wr, in_data, out_rd,
    output out_data, out_ready, full, empty, overflow, underflow
  );
endinterface

// File: rtl/psum_xchg_fifo.sv
// Circular FIFO carrying partial-sum vectors to the peer core, with a batch FSM that
// flags when a full batch of total_cycle vectors is resident.
module psum_xchg_fifo #(
  parameter int bw          = 8,
  parameter int bw_psum     = 2*bw+4,
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int depth       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  psum_xchg_fifo_if.slave            bus,
  output logic [1:0]                 dbg_state,
  output logic [$clog2(depth):0]     dbg_cnt
);
  localparam int W   = bw_psum*col;
  localparam int AW  = $clog2(depth);
  localparam int CW  = AW+1;
  localparam int BCW = $clog2(total_cycle+1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DRAIN = 2'd2} state_t;

  logic [W-1:0]   mem [depth];
  logic [AW-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  state_t         state_q, state_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           out_ready_q, out_ready_d;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic           pop_acc, push_acc;

  // A pop frees a slot in the same cycle, so a push at full is still accepted alongside it.
  assign pop_acc  = bus.out_rd && (cnt_q != '0);
  assign push_acc = bus.in_wr && ((cnt_q != CW'(depth)) || pop_acc);

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q + CW'(push_acc) - CW'(pop_acc);
    out_data_d = out_data_q;
    ovf_d      = ovf_q || (bus.in_wr && !push_acc);
    unf_d      = unf_q || (bus.out_rd && !pop_acc);
    if (push_acc) wp_d = wp_q + AW'(1);
    if (pop_acc) begin
      rp_d       = rp_q + AW'(1);
      out_data_d = mem[rp_q];
    end
  end

  // DRAIN counts pops of the current batch only and never looks at occupancy.
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    out_ready_d = (state_q == ARMED);
    case (state_q)
      IDLE: begin
        if (cnt_d >= CW'(total_cycle)) state_d = ARMED;
      end
      ARMED: begin
        if (pop_acc) begin
          if (total_cycle == 1) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
            bcnt_d  = BCW'(1);
          end
        end
      end
      DRAIN: begin
        if (pop_acc) begin
          if (bcnt_q + BCW'(1) == BCW'(total_cycle)) begin
            state_d = IDLE;
            bcnt_d  = '0;
          end else begin
            bcnt_d  = bcnt_q + BCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      bcnt_q      <= '0;
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_ready_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      bcnt_q      <= bcnt_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_ready_q <= out_ready_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Storage is left uncleared by reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (reset && push_acc) mem[wp_q] <= bus.in_data;
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ready = out_ready_q;
  assign bus.full      = (cnt_q == CW'(depth));
  assign bus.empty     = (cnt_q == '0);
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign dbg_state     = state_q;
  assign dbg_cnt       = cnt_q;
endmodule

// File: doc/psum_xchg_fifo.md
# psum_xchg_fifo

Cross-core partial-sum exchange buffer for the dual-core configuration. Captures one core's `sum_out` vectors while its controller streams them out, holds them in a circular FIFO, and presents them to the peer core's `sum_in`. It raises a batch-ready flag, wired to the peer controller's `fifo_in_ready`, once a full batch of `total_cycle` vectors is resident. It is the stage directly downstream of the local core's sum path and upstream of the peer controller's WAIT/NORM sequence.

## Interface
- `bw`, default 8: activation bit width.
- `bw_psum`, default 2*bw+4: per-column psum width.
- `col`, default 8: columns per vector.
- `total_cycle`, default 8: vectors per batch.
- `depth`, default 16: FIFO entries; a power of two, ≥ `total_cycle`.

Ports:
- `clk` in, 1: single clock; all state updates on posedge.
- `reset` in, 1: synchronous, active-low. `reset==0` at a posedge resets the block.
- `in_wr` in, 1: push strobe (local `fifo_ext_rd`).
- `in_data` in, `bw_psum*col`: pushed vector (local `sum_out`).
- `out_rd` in, 1: pop strobe from the peer side.
- `out_data` out, `bw_psum*col`: registered head vector (peer `sum_in`).
- `out_ready` out, 1: full batch available (peer `fifo_in_ready`).
- `full` out, 1: occupancy == `depth`.
- `empty` out, 1: occupancy == 0.
- `overflow` out, 1: sticky error flag, dropped push.
- `underflow` out, 1: sticky error flag, pop while empty.

## Operation
- Storage: `depth` × `bw_psum*col` array, write pointer `wp`, read pointer `rp`, and occupancy `cnt` (width log2(depth)+1). Pointers wrap modulo `depth`.
- Push accepted when `in_wr` and (`cnt < depth` or a pop is accepted in the same cycle). Accepted push writes `in_data` at `wp`, then `wp++`.
- Push with `cnt==depth` and no accepted pop: data dropped, `overflow` set.
- Pop accepted when `out_rd` and `cnt > 0`. Accepted pop loads `out_data` with the entry at `rp`, then `rp++`.
- Pop with `cnt==0`: ignored, `out_data` holds, `underflow` set. This applies even if a push occurs in the same cycle; no write-through.
- `cnt` update: `cnt + accepted_push − accepted_pop`.
- Batch FSM, states IDLE, ARMED, DRAIN:
  - IDLE → ARMED when next-cycle `cnt ≥ total_cycle`.
  - ARMED → DRAIN on first accepted pop; `bcnt` set to 1.
  - DRAIN: `bcnt` increments per accepted pop. When the accepted pop makes `bcnt == total_cycle`, go to IDLE.
  - DRAIN ignores `cnt`, so stalled pops simply hold the state.
  - From IDLE, re-arming follows the normal rule, allowing back-to-back batches.
- `out_ready` = 1 only in ARMED, registered from the FSM state.
- `full` and `empty` are decoded from registered `cnt`.
- `overflow` and `underflow` stay set until reset.

## Timing
- Reset (`reset==0` at posedge):
  - `wp`, `rp`, `cnt`, `bcnt` cleared; FSM to IDLE.
  - `out_data` = 0, `out_ready` = 0, `full` = 0, `empty` = 1, `overflow` = 0, `underflow` = 0.
  - Array contents are not cleared.
  - Reset mid-batch discards all contents and any pending pops.
- Push-to-visible latency: a push at edge N is poppable at edge N+1 (`empty` falls after edge N).
- Pop latency: `out_rd` sampled at edge N; `out_data` valid after edge N, stable until the next accepted pop.
- `out_ready` rises one edge after the push that brings `cnt` to `total_cycle`. It falls one edge after the first accepted pop.
- Full throughput: one push and one pop per cycle, including simultaneous push/pop at `cnt==depth` (accepted, `cnt` unchanged) and at `cnt==0` (push only).
- Pointer wrap from `depth-1` to 0 has no bubble.

## Test plan
- Reset, then push 8 vectors (column k of vector i = i*16+k), one per cycle:
  - `out_ready` rises on the edge after the 8th push.
  - Then pop 8 back-to-back: `out_data` returns vectors 0..7 in order, one per cycle.
  - `out_ready` drops after the first pop; `empty` is set after the 8th pop.
- Push 16 vectors: `full`=1. A 17th push alone sets `overflow`, and `cnt` stays 16. A simultaneous push+pop at full is accepted; the pushed value appears as the 16th subsequent pop.
- Pop when empty: `underflow`=1 and `out_data` holds its last value. Push+pop together on empty: `cnt`=1 and `underflow` is set.
- Interleaved traffic of 40 pushes and 40 pops with random gaps, covering pointer wrap: the read sequence matches the write sequence exactly, and `out_ready` asserts exactly 5 times.
- Assert `reset`=0 after 5 of 8 pops of a batch: all outputs return to their reset values the next edge. A fresh 8-push batch then behaves as in scenario 1.
- Push 8, pop 3, stall 4 cycles, push 8 more, pop 5: FSM returns IDLE and re-arms on the next edge (`cnt`=8), raising `out_ready` again.
